// File: rtl/mc_controller.sv
// mc_controller: multicycle MIPS control FSM with combinational ALU decoder.
// Optional bne support is compiled in when the MC_BNE_EN macro is defined.
module mc_controller (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    output logic       pcen,
    output logic       irwrite,
    output logic       regwrite,
    output logic       memwrite,
    output logic       alusrca,
    output logic       iord,
    output logic       memtoreg,
    output logic       regdst,
    output logic [1:0] alusrcb,
    output logic [1:0] pcsrc,
    output logic [2:0] alucontrol,
    output logic       badop
);

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR,
        S_EXECUTE, S_ALUWB, S_BRANCH, S_ADDIEX, S_ADDIWB, S_JUMP
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    state_t     state_q, state_d;
    logic       pcwrite;
    logic       branch;
    logic [1:0] aluop;
    logic       rtype_ok;

    assign rtype_ok = (funct == FN_ADD) || (funct == FN_SUB) || (funct == FN_AND) ||
                      (funct == FN_OR)  || (funct == FN_SLT);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        // NOTE: every output gets a default first, so no path through the case infers a latch.
        state_d  = state_q;
        pcwrite  = 1'b0;
        branch   = 1'b0;
        irwrite  = 1'b0;
        regwrite = 1'b0;
        memwrite = 1'b0;
        alusrca  = 1'b0;
        iord     = 1'b0;
        memtoreg = 1'b0;
        regdst   = 1'b0;
        alusrcb  = 2'b00;
        pcsrc    = 2'b00;
        aluop    = 2'b00;
        badop    = 1'b0;

        case (state_q)
            S_FETCH: begin
                alusrcb = 2'b01;
                irwrite = 1'b1;
                pcwrite = 1'b1;
                state_d = S_DECODE;
            end
            S_DECODE: begin
                alusrcb = 2'b11;
                case (op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE: begin
                        if (rtype_ok) begin
                            state_d = S_EXECUTE;
                        end else begin
                            badop   = 1'b1;
                            state_d = S_FETCH;
                        end
                    end
                    OP_BEQ:  state_d = S_BRANCH;
                    OP_ADDI: state_d = S_ADDIEX;
                    OP_J:    state_d = S_JUMP;
`ifdef MC_BNE_EN
                    6'b000101: state_d = S_BRANCH;
`endif
                    default: begin
                        badop   = 1'b1;
                        state_d = S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
                state_d = (op == OP_LW) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                iord    = 1'b1;
                state_d = S_MEMWB;
            end
            S_MEMWB: begin
                memtoreg = 1'b1;
                regwrite = 1'b1;
                state_d  = S_FETCH;
            end
            S_MEMWR: begin
                iord     = 1'b1;
                memwrite = 1'b1;
                state_d  = S_FETCH;
            end
            S_EXECUTE: begin
                alusrca = 1'b1;
                aluop   = 2'b10;
                state_d = S_ALUWB;
            end
            S_ALUWB: begin
                regdst   = 1'b1;
                regwrite = 1'b1;
                state_d  = S_FETCH;
            end
            S_BRANCH: begin
                alusrca = 1'b1;
                aluop   = 2'b01;
                pcsrc   = 2'b01;
                branch  = 1'b1;
                state_d = S_FETCH;
            end
            S_ADDIEX: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
                state_d = S_ADDIWB;
            end
            S_ADDIWB: begin
                regwrite = 1'b1;
                state_d  = S_FETCH;
            end
            S_JUMP: begin
                pcsrc   = 2'b10;
                pcwrite = 1'b1;
                state_d = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase
    end

`ifdef MC_BNE_EN
    // The instruction register still holds op in BRANCH, so bne is recovered from it there.
    logic bne;
    assign bne  = branch && (op == 6'b000101);
    assign pcen = pcwrite | (branch & ~bne & zero) | (bne & ~zero);
`else
    assign pcen = pcwrite | (branch & zero);
`endif

    always_comb begin
        alucontrol = 3'b010;
        case (aluop)
            2'b00: alucontrol = 3'b010;
            2'b01: alucontrol = 3'b110;
            default: begin
                case (funct)
                    FN_ADD:  alucontrol = 3'b010;
                    FN_SUB:  alucontrol = 3'b110;
                    FN_AND:  alucontrol = 3'b000;
                    FN_OR:   alucontrol = 3'b001;
                    FN_SLT:  alucontrol = 3'b111;
                    default: alucontrol = 3'b010;
                endcase
            end
        endcase
    end

endmodule

// File: tb/tb_mc_controller.sv
// Directed self-checking bench for mc_controller: walks each instruction class
// state by state and compares the full output vector against hand-built values.
module tb_mc_controller;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    logic       pcen, irwrite, regwrite, memwrite, alusrca, iord, memtoreg, regdst, badop;
    logic [1:0] alusrcb, pcsrc;
    logic [2:0] alucontrol;

    int n_checks = 0;
    int n_fail   = 0;

    mc_controller dut (
        .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
        .pcen(pcen), .irwrite(irwrite), .regwrite(regwrite), .memwrite(memwrite),
        .alusrca(alusrca), .iord(iord), .memtoreg(memtoreg), .regdst(regdst),
        .alusrcb(alusrcb), .pcsrc(pcsrc), .alucontrol(alucontrol), .badop(badop)
    );

    always #5 clk = ~clk;

    // Packed view: pcen irwrite regwrite memwrite alusrca iord memtoreg regdst alusrcb pcsrc alucontrol badop
    function automatic logic [15:0] outs();
        return {pcen, irwrite, regwrite, memwrite, alusrca, iord, memtoreg, regdst,
                alusrcb, pcsrc, alucontrol, badop};
    endfunction

    function automatic logic [15:0] mk(input logic pe, input logic irw, input logic rw, input logic mw,
                                       input logic sa, input logic io, input logic m2r, input logic rd,
                                       input logic [1:0] sb, input logic [1:0] ps, input logic [2:0] ac,
                                       input logic bo);
        return {pe, irw, rw, mw, sa, io, m2r, rd, sb, ps, ac, bo};
    endfunction

    // Hand-derived output vectors per state.
    logic [15:0] E_FETCH, E_DECODE, E_DECODE_BAD, E_MEMADR, E_MEMRD, E_MEMWB, E_MEMWR;
    logic [15:0] E_EXEC_SLT, E_ALUWB, E_BR_TAKEN, E_BR_NOT, E_ADDIEX, E_ADDIWB, E_JUMP;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        // reset held from time 0: outputs must already show FETCH decode
        #2;
        n_checks++;
        if (outs() !== E_FETCH) begin
            n_fail++;
            $display("FAIL reset_hold: got %h expected %h", outs(), E_FETCH);
        end
        tick();
        reset = 1'b0;
        op    = 6'b100011;
        tick();
        n_checks++;
        if (outs() !== E_DECODE) begin
            n_fail++;
            $display("FAIL reset_to_decode: got %h expected %h", outs(), E_DECODE);
        end
        // asynchronous assert while in DECODE
        #2 reset = 1'b1;
        #1;
        n_checks++;
        if (outs() !== E_FETCH) begin
            n_fail++;
            $display("FAIL reset_async_in_decode: got %h expected %h", outs(), E_FETCH);
        end
        #2 reset = 1'b0;
        #1;
        n_checks++;
        if (outs() !== E_FETCH) begin
            n_fail++;
            $display("FAIL reset_release_fetch: got %h expected %h", outs(), E_FETCH);
        end
        tick();
        n_checks++;
        if (outs() !== E_DECODE) begin
            n_fail++;
            $display("FAIL reset_first_fetch: got %h expected %h", outs(), E_DECODE);
        end
        tick();
        tick();
        tick();
        tick();
        // lw finished after 5 cycles, now in FETCH
        n_checks++;
        if (outs() !== E_FETCH) begin
            n_fail++;
            $display("FAIL reset_settle_fetch: got %h expected %h", outs(), E_FETCH);
        end
    endtask

    task automatic test_lw();
        logic [15:0] exp_q[$];
        op     = 6'b100011;
        funct  = 6'b000000;
        exp_q  = '{E_FETCH, E_DECODE, E_MEMADR, E_MEMRD, E_MEMWB, E_FETCH};
        for (int i = 0; i < exp_q.size(); i++) begin
            n_checks++;
            if (outs() !== exp_q[i]) begin
                n_fail++;
                $display("FAIL lw_step%0d: got %h expected %h", i, outs(), exp_q[i]);
            end
            if (i < exp_q.size() - 1) tick();
        end
    endtask

    task automatic test_rtype();
        logic [15:0] exp_q[$];
        op     = 6'b000000;
        funct  = 6'b101010;
        exp_q  = '{E_FETCH, E_DECODE, E_EXEC_SLT, E_ALUWB, E_FETCH};
        for (int i = 0; i < exp_q.size(); i++) begin
            n_checks++;
            if (outs() !== exp_q[i]) begin
                n_fail++;
                $display("FAIL rtype_slt_step%0d: got %h expected %h", i, outs(), exp_q[i]);
            end
            if (i < exp_q.size() - 1) tick();
        end
    endtask

    task automatic test_beq();
        logic [15:0] exp_q[$];
        for (int pass = 0; pass < 2; pass++) begin
            op    = 6'b000100;
            funct = 6'b100101;
            zero  = (pass == 0);
            exp_q = '{E_FETCH, E_DECODE, (pass == 0) ? E_BR_TAKEN : E_BR_NOT, E_FETCH};
            for (int i = 0; i < exp_q.size(); i++) begin
                n_checks++;
                if (outs() !== exp_q[i]) begin
                    n_fail++;
                    $display("FAIL beq_zero%0d_step%0d: got %h expected %h", zero, i, outs(), exp_q[i]);
                end
                if (i < exp_q.size() - 1) tick();
            end
        end
        zero = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [15:0] exp_q[$];
        // sw then j, no idle cycles between them
        op    = 6'b101011;
        exp_q = '{E_FETCH, E_DECODE, E_MEMADR, E_MEMWR};
        for (int i = 0; i < exp_q.size(); i++) begin
            n_checks++;
            if (outs() !== exp_q[i]) begin
                n_fail++;
                $display("FAIL sw_step%0d: got %h expected %h", i, outs(), exp_q[i]);
            end
            tick();
        end
        op    = 6'b000010;
        exp_q = '{E_FETCH, E_DECODE, E_JUMP, E_FETCH};
        for (int i = 0; i < exp_q.size(); i++) begin
            n_checks++;
            if (outs() !== exp_q[i]) begin
                n_fail++;
                $display("FAIL j_step%0d: got %h expected %h", i, outs(), exp_q[i]);
            end
            if (i < exp_q.size() - 1) tick();
        end
    endtask

    task automatic test_addi();
        logic [15:0] exp_q[$];
        op    = 6'b001000;
        funct = 6'b100010;
        exp_q = '{E_FETCH, E_DECODE, E_ADDIEX, E_ADDIWB, E_FETCH};
        for (int i = 0; i < exp_q.size(); i++) begin
            n_checks++;
            if (outs() !== exp_q[i]) begin
                n_fail++;
                $display("FAIL addi_step%0d: got %h expected %h", i, outs(), exp_q[i]);
            end
            if (i < exp_q.size() - 1) tick();
        end
    endtask

    task automatic test_badop();
        logic [15:0] exp_q[$];
        // unsupported R-type funct, then an unknown opcode
        op    = 6'b000000;
        funct = 6'b000000;
        exp_q = '{E_FETCH, E_DECODE_BAD, E_FETCH};
        for (int i = 0; i < exp_q.size(); i++) begin
            n_checks++;
            if (outs() !== exp_q[i]) begin
                n_fail++;
                $display("FAIL bad_rtype_step%0d: got %h expected %h", i, outs(), exp_q[i]);
            end
            if (i < exp_q.size() - 1) tick();
        end
        op = 6'b111111;
        for (int i = 0; i < exp_q.size(); i++) begin
            n_checks++;
            if (outs() !== exp_q[i]) begin
                n_fail++;
                $display("FAIL bad_op_step%0d: got %h expected %h", i, outs(), exp_q[i]);
            end
            if (i < exp_q.size() - 1) tick();
        end
    endtask

    task automatic test_bne();
        logic [15:0] exp_q[$];
        op    = 6'b000101;
        funct = 6'b000000;
        for (int pass = 0; pass < 2; pass++) begin
            zero = (pass == 1);
`ifdef MC_BNE_EN
            exp_q = '{E_FETCH, E_DECODE, (pass == 0) ? E_BR_TAKEN : E_BR_NOT, E_FETCH};
`else
            exp_q = '{E_FETCH, E_DECODE_BAD, E_FETCH};
`endif
            for (int i = 0; i < exp_q.size(); i++) begin
                n_checks++;
                if (outs() !== exp_q[i]) begin
                    n_fail++;
                    $display("FAIL bne_zero%0d_step%0d: got %h expected %h", zero, i, outs(), exp_q[i]);
                end
                if (i < exp_q.size() - 1) tick();
            end
        end
        zero = 1'b0;
    endtask

    task automatic test_reset_mid_lw();
        op    = 6'b100011;
        funct = 6'b000000;
        tick();
        tick();
        tick();
        n_checks++;
        if (outs() !== E_MEMRD) begin
            n_fail++;
            $display("FAIL midlw_memrd: got %h expected %h", outs(), E_MEMRD);
        end
        #2 reset = 1'b1;
        #1;
        n_checks++;
        if (outs() !== E_FETCH) begin
            n_fail++;
            $display("FAIL midlw_abort: got %h expected %h", outs(), E_FETCH);
        end
        tick();
        n_checks++;
        if (outs() !== E_FETCH) begin
            n_fail++;
            $display("FAIL midlw_held_no_write: got %h expected %h", outs(), E_FETCH);
        end
        reset = 1'b0;
        tick();
        n_checks++;
        if (outs() !== E_DECODE) begin
            n_fail++;
            $display("FAIL midlw_restart_decode: got %h expected %h", outs(), E_DECODE);
        end
        // finish this lw so later tests start from FETCH
        tick();
        tick();
        tick();
        tick();
        n_checks++;
        if (outs() !== E_FETCH) begin
            n_fail++;
            $display("FAIL midlw_final_fetch: got %h expected %h", outs(), E_FETCH);
        end
    endtask

    initial begin
        E_FETCH      = mk(1, 1, 0, 0, 0, 0, 0, 0, 2'b01, 2'b00, 3'b010, 0);
        E_DECODE     = mk(0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 2'b00, 3'b010, 0);
        E_DECODE_BAD = mk(0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 2'b00, 3'b010, 1);
        E_MEMADR     = mk(0, 0, 0, 0, 1, 0, 0, 0, 2'b10, 2'b00, 3'b010, 0);
        E_MEMRD      = mk(0, 0, 0, 0, 0, 1, 0, 0, 2'b00, 2'b00, 3'b010, 0);
        E_MEMWB      = mk(0, 0, 1, 0, 0, 0, 1, 0, 2'b00, 2'b00, 3'b010, 0);
        E_MEMWR      = mk(0, 0, 0, 1, 0, 1, 0, 0, 2'b00, 2'b00, 3'b010, 0);
        E_EXEC_SLT   = mk(0, 0, 0, 0, 1, 0, 0, 0, 2'b00, 2'b00, 3'b111, 0);
        E_ALUWB      = mk(0, 0, 1, 0, 0, 0, 0, 1, 2'b00, 2'b00, 3'b010, 0);
        E_BR_TAKEN   = mk(1, 0, 0, 0, 1, 0, 0, 0, 2'b00, 2'b01, 3'b110, 0);
        E_BR_NOT     = mk(0, 0, 0, 0, 1, 0, 0, 0, 2'b00, 2'b01, 3'b110, 0);
        E_ADDIEX     = mk(0, 0, 0, 0, 1, 0, 0, 0, 2'b10, 2'b00, 3'b010, 0);
        E_ADDIWB     = mk(0, 0, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 3'b010, 0);
        E_JUMP       = mk(1, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 3'b010, 0);

        reset = 1'b1;
        op    = 6'b000000;
        funct = 6'b000000;
        zero  = 1'b0;

        test_reset();
        test_lw();
        test_rtype();
        test_beq();
        test_back_to_back();
        test_addi();
        test_badop();
        test_bne();
        test_reset_mid_lw();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
